// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - N-master CPU memory bus arbiter with bus locking
// Optional round-robin selection: define CPU_BUS_ARB_ROUND_ROBIN_EN (fixed priority otherwise).
module cpu_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS-1:0]        lock,
    input  logic [NUM_MASTERS-1:0]        wr_en,
    input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] wdata,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic [DATA_W-1:0]             rdata,
    output logic [NUM_MASTERS-1:0]        rdata_valid,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_data_out,
    output logic                          mem_write_en,
    output logic                          mem_read_en,
    input  logic [DATA_W-1:0]             mem_data_in
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t                 state, state_nxt;
    // owner also serves as the round-robin pointer: it keeps the last owner while idle
    logic [IDX_W-1:0]       owner, owner_nxt;
    logic [IDX_W-1:0]       cand;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic                   found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            grant       <= '0;
            rdata       <= '0;
            rdata_valid <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            grant       <= grant_nxt;
            rdata_valid <= '0;
            if (mem_read_en) begin
                rdata       <= mem_data_in;
                rdata_valid <= grant;
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        owner_nxt = owner;
        cand      = '0;
        found     = 1'b0;
        grant_nxt = '0;
        if (state == OWNED && req[owner] && lock[owner]) begin
            state_nxt = OWNED;
        end else begin
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
            // search begins just after the last owner and wraps; the owner itself is tried last
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                cand = IDX_W'((int'(owner) + k) % NUM_MASTERS);
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    owner_nxt = cand;
                end
            end
`else
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                cand = IDX_W'(k);
                if (req[cand]) begin
                    found     = 1'b1;
                    owner_nxt = cand;
                end
            end
`endif
            if (found) begin
                state_nxt = OWNED;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_nxt[i] = (state_nxt == OWNED) && (owner_nxt == IDX_W'(i));
        end
    end

    always_comb begin
        mem_addr     = '0;
        mem_data_out = '0;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i] && req[i]) begin
                mem_addr     = addr[i*ADDR_W +: ADDR_W];
                mem_data_out = wdata[i*DATA_W +: DATA_W];
                mem_write_en = wr_en[i];
                mem_read_en  = !wr_en[i];
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - directed table-driven bench for cpu_bus_arbiter
module tb_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, lock, wr_en;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [3:0]  grant;
    logic [7:0]  rdata;
    logic [3:0]  rdata_valid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [7:0]  mem_data_in;

    int total = 0;
    int bad   = 0;

`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [3:0] FIRST_GNT = RR ? 4'b0010 : 4'b0001;

    cpu_bus_arbiter #(.NUM_MASTERS(4), .ADDR_W(16), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .lock         (lock),
        .wr_en        (wr_en),
        .addr         (addr),
        .wdata        (wdata),
        .grant        (grant),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_data_in  (mem_data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [3:0]  wr;
        logic [7:0]  mdin;
        logic [3:0]  e_grant;
        logic        e_rd;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [3:0]  e_rv;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vecs[20];
    logic [15:0] base_addr[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        base_addr = '{16'h0f00, 16'h1001, 16'h2002, 16'h3003};
        for (int i = 0; i < 4; i++) begin
            addr[i*16 +: 16] = base_addr[i];
            wdata[i*8 +: 8]  = 8'h10 + 8'(i);
        end
        rst = 1'b1; req = '0; lock = '0; wr_en = '0; mem_data_in = '0;

        //          rst   req      lock     wr       mdin   grant      rd    wr    addr      rv       rdata
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 8'h00, 4'b0000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h00};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 8'h00, 4'b0000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h00};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 8'h00, 4'b0000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h00};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, FIRST_GNT, 1'b0, 1'b0, 16'h0000, 4'b0000, 8'h00};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h00};
        vecs[5]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 8'h80, 4'b0000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h00};
        vecs[6]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 8'h80, 4'b0100,  1'b1, 1'b0, 16'h2002, 4'b0000, 8'h00};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0100,  1'b0, 1'b0, 16'h0000, 4'b0100, 8'h80};
        vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h80};
        vecs[9]  = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 8'h00, 4'b0000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h80};
        vecs[10] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 8'h00, 4'b1000,  1'b0, 1'b1, 16'h3003, 4'b0000, 8'h80};
        vecs[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b1000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h80};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h80};
        vecs[13] = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 8'h00, 4'b0000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h80};
        vecs[14] = '{1'b0, 4'b0011, 4'b0010, 4'b0000, 8'h11, 4'b0010,  1'b1, 1'b0, 16'h1001, 4'b0000, 8'h80};
        vecs[15] = '{1'b0, 4'b0011, 4'b0010, 4'b0000, 8'h22, 4'b0010,  1'b1, 1'b0, 16'h1001, 4'b0010, 8'h11};
        vecs[16] = '{1'b0, 4'b0011, 4'b0000, 4'b0000, 8'h33, 4'b0010,  1'b1, 1'b0, 16'h1001, 4'b0010, 8'h22};
        vecs[17] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 8'h44, 4'b0001,  1'b1, 1'b0, 16'h0f00, 4'b0010, 8'h33};
        vecs[18] = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 8'h00, 4'b0001,  1'b0, 1'b0, 16'h0000, 4'b0001, 8'h44};
        vecs[19] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000,  1'b0, 1'b0, 16'h0000, 4'b0000, 8'h44};

        for (int r = 0; r < 20; r++) begin
            tick();
            rst = vecs[r].rst; req = vecs[r].req; lock = vecs[r].lock;
            wr_en = vecs[r].wr; mem_data_in = vecs[r].mdin;
            #1;
            check($sformatf("v%0d grant", r), 32'(grant), 32'(vecs[r].e_grant));
            check($sformatf("v%0d mem_read_en", r), 32'(mem_read_en), 32'(vecs[r].e_rd));
            check($sformatf("v%0d mem_write_en", r), 32'(mem_write_en), 32'(vecs[r].e_wr));
            check($sformatf("v%0d mem_addr", r), 32'(mem_addr), 32'(vecs[r].e_addr));
            check($sformatf("v%0d rdata_valid", r), 32'(rdata_valid), 32'(vecs[r].e_rv));
            check($sformatf("v%0d rdata", r), 32'(rdata), 32'(vecs[r].e_rdata));
        end

        // contention: all masters write, nobody locks; table leaves the last owner at 0
        tick();
        req = 4'b1111; wr_en = 4'b1111; lock = '0;
        for (int c = 0; c < 5; c++) begin
            int e;
            tick();
            e = RR ? ((c + 1) % 4) : 0;
            check($sformatf("contend%0d grant", c), 32'(grant), 32'(4'b0001 << e));
            check($sformatf("contend%0d bus", c), {15'd0, mem_write_en, mem_addr},
                  {15'd0, 1'b1, base_addr[e]});
            check($sformatf("contend%0d wdata", c), 32'(mem_data_out), 32'(8'h10 + 8'(e)));
        end
        req = '0; wr_en = '0;
        tick();
        tick();
        check("contend idle grant", 32'(grant), 32'h0);

        // locked 256-byte write burst by master 1; master 0 requests a read mid-burst
        req = 4'b0010; lock = 4'b0010; wr_en = 4'b0010; addr[16 +: 16] = 16'h0200;
        tick();
        for (int k = 0; k < 256; k++) begin
            addr[16 +: 16] = 16'h0200 + 16'(k);
            if (k == 100) req[0] = 1'b1;
            #1;
            check($sformatf("burst%0d", k), {11'd0, grant, mem_write_en, mem_addr},
                  {11'd0, 4'b0010, 1'b1, 16'h0200 + 16'(k)});
            tick();
        end
        req[1] = 1'b0; lock[1] = 1'b0;
        #1;
        check("burst end no transfer", 32'({grant, mem_write_en, mem_read_en}), 32'({4'b0010, 1'b0, 1'b0}));
        tick();
        check("handover grant", 32'(grant), 32'h1);
        check("handover read", 32'({mem_read_en, mem_addr}), 32'({1'b1, 16'h0f00}));
        req = '0; wr_en = '0; addr[16 +: 16] = base_addr[1];
        tick();
        tick();

        // reset asserted in the cycle a read is accepted
        req = 4'b0100; mem_data_in = 8'h5a;
        tick();
        check("rstmid accepted", 32'({grant, mem_read_en}), 32'({4'b0100, 1'b1}));
        rst = 1'b1;
        tick();
        check("rstmid rdata_valid", 32'(rdata_valid), 32'h0);
        check("rstmid grant", 32'(grant), 32'h0);
        check("rstmid rdata", 32'(rdata), 32'h0);
        rst = 1'b0;
        #1;
        check("rstmid bus idle", 32'({mem_read_en, mem_write_en}), 32'h0);
        tick();
        check("rstmid regrant", 32'(grant), 32'h4);
        check("rstmid no stale valid", 32'(rdata_valid), 32'h0);
        req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
